ps2_kbd_ctrl: RTL and testbench

Controller that sequences the PS/2 keyboard receiver and turns raw scan codes into key events.
- Watches the receiver's 9-bit output {valid, code[7:0]}.
- Acknowledges each code by pulsing the receiver's sel input, which clears the receiver's valid bit on sel's falling edge.
- Folds the E0 (extended) and F0 (break) prefixes into event flags and queues events in a small FIFO.
- The CPU pops events with a read strobe that has the same falling-edge semantics.

---
 rtl/ps2_kbd_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: handshakes scan codes out of the receiver, folds E0/F0 prefixes
// into event flags and queues events for the CPU. Optional: PS2_KBD_TYPEMATIC_FILTER_EN.
module ps2_kbd_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned PTR_W          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       rx_data,
  output logic             rx_ack,
  input  logic             rd_sel,
  output logic [10:0]      rd_data,
  output logic [PTR_W:0]   fifo_count,
  output logic             overflow,
  output logic             kbd_err,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, PARSE, WAIT_CLR} state_t;

  state_t           state;
  logic [1:0]       rst_sync;
  logic             rst_n;
  logic [7:0]       byte_q;
  logic             ext_flag;
  logic             brk_flag;
  logic [15:0]      timer;
  logic             rd_sel_q;
  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic is_e0, is_f0, is_bad, is_code;
  logic push, pop, full, push_ok, drop, timeout;

  // Assert asynchronously, release two clocks after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign is_e0   = (byte_q == 8'hE0);
  assign is_f0   = (byte_q == 8'hF0);
  assign is_bad  = (byte_q == 8'h00) || (byte_q == 8'hFF);
  assign is_code = (state == PARSE) && !is_e0 && !is_f0 && !is_bad;
  assign timeout = (ext_flag || brk_flag) && (timer == 16'(TIMEOUT_CYCLES - 1));

`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
  logic       last_vld;
  logic [8:0] last_key;
  logic       repeat_hit;

  assign repeat_hit = !brk_flag && last_vld && (last_key == {ext_flag, byte_q});
  assign push       = is_code && !repeat_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_vld <= 1'b0;
      last_key <= '0;
    end else if (is_code) begin
      if (brk_flag) begin
        last_vld <= 1'b0;
      end else begin
        last_vld <= 1'b1;
        last_key <= {ext_flag, byte_q};
      end
    end
  end
`else
  assign push = is_code;
`endif

  assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop     = rd_sel_q && !rd_sel && (count != '0);
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rx_ack <= 1'b0;
      byte_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          rx_ack <= 1'b0;
          if (rx_data[8]) begin
            byte_q <= rx_data[7:0];
            rx_ack <= 1'b1;
            state  <= PARSE;
          end
        end
        PARSE: begin
          rx_ack <= 1'b0;
          state  <= WAIT_CLR;
        end
        WAIT_CLR: begin
          rx_ack <= 1'b0;
          if (!rx_data[8]) state <= IDLE;
        end
        default: begin
          rx_ack <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Parse writes come after the timeout clear so a prefix arriving on the expiry cycle still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      timer    <= '0;
    end else begin
      if (timeout) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        timer    <= '0;
      end else if (ext_flag || brk_flag) begin
        timer <= timer + 16'd1;
      end
      if (state == PARSE) begin
        if (is_e0) begin
          ext_flag <= 1'b1;
          timer    <= '0;
        end else if (is_f0) begin
          brk_flag <= 1'b1;
          timer    <= '0;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          timer    <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      kbd_err  <= 1'b0;
    end else begin
      if (pop && (count == (PTR_W + 1)'(1)) && !push_ok) begin
        overflow <= 1'b0;
        kbd_err  <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
      if ((state == PARSE) && is_bad) kbd_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel_q <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      rd_sel_q <= rd_sel;
      if (push_ok) tail <= tail + 1'b1;
      if (pop)     head <= head + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= {ext_flag, brk_flag, byte_q};
  end

  assign rd_data    = (count != '0) ? {1'b1, mem[head]} : '0;
  assign fifo_count = count;
  assign irq        = (count != '0);

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: vector table of handshakes/pops plus hand-written
// sequences for timeout, simultaneous push/pop, typematic repeats and mid-operation reset.
module tb_ps2_kbd_ctrl;

  localparam int unsigned TO = 40;

  logic        clk;
  logic        rst;
  logic [8:0]  rx_data;
  logic        rx_ack;
  logic        rd_sel;
  logic [10:0] rd_data;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        kbd_err;
  logic        irq;

  int n_cmp;
  int n_fail;

  typedef struct {
    bit          is_pop;
    logic [7:0]  code;
    logic [10:0] exp_rd;
    logic [3:0]  exp_cnt;
    logic        exp_ovf;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  ps2_kbd_ctrl #(
    .FIFO_DEPTH(8),
    .PTR_W(3),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_ack(rx_ack),
    .rd_sel(rd_sel),
    .rd_data(rd_data),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .kbd_err(kbd_err),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] code);
    int t;
    t = 0;
    @(negedge clk);
    rx_data = {1'b1, code};
    while (!rx_ack && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ack) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout: got rx_ack 0 expected 1 for code %0h", code);
    end
    @(negedge clk);
    rx_data[8] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_sel = 1'b1;
    @(negedge clk);
    rd_sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_and_pop(input logic [7:0] code);
    @(negedge clk);
    rx_data = {1'b1, code};
    rd_sel  = 1'b1;
    @(negedge clk);
    rd_sel = 1'b0;
    check("pp_ack", 32'(rx_ack), 32'd1);
    @(negedge clk);
    rx_data[8] = 1'b0;
    @(negedge clk);
  endtask

  task automatic add(input bit p, input logic [7:0] c, input logic [10:0] rd,
                     input logic [3:0] cnt, input logic ovf, input logic err);
    vec_t v;
    v.is_pop = p; v.code = c; v.exp_rd = rd; v.exp_cnt = cnt; v.exp_ovf = ovf; v.exp_err = err;
    vt.push_back(v);
  endtask

  initial begin
    int hi;
    int exp_n;
    logic [10:0] exp_q[$];
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    rx_data = '0;
    rd_sel = 1'b0;

    add(0, 8'h1C, 11'h41C, 4'd1, 0, 0);
    add(1, 8'h00, 11'h000, 4'd0, 0, 0);
    add(0, 8'hE0, 11'h000, 4'd0, 0, 0);
    add(0, 8'hF0, 11'h000, 4'd0, 0, 0);
    add(0, 8'h75, 11'h775, 4'd1, 0, 0);
    add(1, 8'h00, 11'h000, 4'd0, 0, 0);
    add(0, 8'hE0, 11'h000, 4'd0, 0, 0);
    add(0, 8'h12, 11'h612, 4'd1, 0, 0);
    add(0, 8'hE1, 11'h612, 4'd2, 0, 0);
    add(1, 8'h00, 11'h4E1, 4'd1, 0, 0);
    add(1, 8'h00, 11'h000, 4'd0, 0, 0);
    add(0, 8'hFF, 11'h000, 4'd0, 0, 1);
    add(0, 8'h00, 11'h000, 4'd0, 0, 1);
    add(0, 8'h1C, 11'h41C, 4'd1, 0, 1);
    add(1, 8'h00, 11'h000, 4'd0, 0, 0);
    add(0, 8'hF0, 11'h000, 4'd0, 0, 0);
    add(0, 8'hFF, 11'h000, 4'd0, 0, 1);
    add(0, 8'h2A, 11'h42A, 4'd1, 0, 1);
    add(1, 8'h00, 11'h000, 4'd0, 0, 0);
    for (int i = 0; i < 9; i++)
      add(0, 8'(8'h15 + i), 11'h415, (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 0);
    for (int i = 0; i < 8; i++)
      add(1, 8'h00, (i < 7) ? 11'(11'h416 + i) : 11'h000, 4'(7 - i), (i < 7), 0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(rx_ack), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_err", 32'(kbd_err), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    foreach (vt[i]) begin
      if (vt[i].is_pop) pop();
      else              send(vt[i].code);
      check($sformatf("v%0d_rd", i), 32'(rd_data), 32'(vt[i].exp_rd));
      check($sformatf("v%0d_cnt", i), 32'(fifo_count), 32'(vt[i].exp_cnt));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vt[i].exp_ovf));
      check($sformatf("v%0d_err", i), 32'(kbd_err), 32'(vt[i].exp_err));
      check($sformatf("v%0d_irq", i), 32'(irq), 32'(vt[i].exp_cnt != 4'd0));
    end

    // rx_ack is a single-cycle pulse
    hi = 0;
    @(negedge clk);
    rx_data = {1'b1, 8'h2C};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rx_ack) hi++;
      else if (hi > 0) rx_data[8] = 1'b0;
    end
    check("ack_width", 32'(hi), 32'd1);
    check("ack_rd", 32'(rd_data), 32'h42C);
    check("ack_irq", 32'(irq), 32'd1);
    pop();

    // Break prefix expires, then survives when the code follows quickly
    send(8'hF0);
    repeat (TO + 2) @(negedge clk);
    send(8'h1C);
    check("to_expired", 32'(rd_data), 32'h41C);
    pop();
    send(8'hF0);
    send(8'h1C);
    check("to_live", 32'(rd_data), 32'h51C);
    pop();

    // Push and pop on the same edge while full
    for (int i = 0; i < 8; i++) send(8'(8'h30 + i));
    check("full_cnt", 32'(fifo_count), 32'd8);
    push_and_pop(8'h38);
    check("fpp_cnt", 32'(fifo_count), 32'd8);
    check("fpp_ovf", 32'(overflow), 32'd0);
    check("fpp_rd", 32'(rd_data), 32'h431);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), 32'(rd_data), 32'(11'h431 + i));
      pop();
    end
    check("drain_cnt", 32'(fifo_count), 32'd0);

    // Push and pop on the same edge at count 1
    send(8'h40);
    push_and_pop(8'h41);
    check("one_cnt", 32'(fifo_count), 32'd1);
    check("one_rd", 32'(rd_data), 32'h441);
    pop();
    check("one_empty", 32'(fifo_count), 32'd0);

    // Auto-repeat sequence
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'h1C);
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
    exp_q = '{11'h41C, 11'h51C, 11'h41C};
`else
    exp_q = '{11'h41C, 11'h41C, 11'h41C, 11'h51C, 11'h41C};
`endif
    exp_n = exp_q.size();
    check("tm_cnt", 32'(fifo_count), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      check($sformatf("tm%0d", i), 32'(rd_data), 32'(exp_q[i]));
      pop();
    end

    // Error code held in WAIT_CLR, consumed once, then reset mid-operation
    send(8'h4B);
    @(negedge clk);
    rx_data = {1'b1, 8'hFF};
    hi = 0;
    while (!rx_ack && hi < 20) begin
      @(negedge clk);
      hi++;
    end
    check("err_ack", 32'(rx_ack), 32'd1);
    @(negedge clk);
    check("err_flag", 32'(kbd_err), 32'd1);
    check("err_cnt", 32'(fifo_count), 32'd1);
    repeat (3) @(negedge clk);
    check("once_cnt", 32'(fifo_count), 32'd1);
    rst = 1'b0;
    #1;
    check("mrst_ack", 32'(rx_ack), 32'd0);
    check("mrst_rd", 32'(rd_data), 32'd0);
    check("mrst_cnt", 32'(fifo_count), 32'd0);
    check("mrst_ovf", 32'(overflow), 32'd0);
    check("mrst_err", 32'(kbd_err), 32'd0);
    check("mrst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rx_data = '0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h2C);
    check("post_rst_rd", 32'(rd_data), 32'h42C);
    check("post_rst_cnt", 32'(fifo_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
